// File: rtl/anti_theft_pkg.sv
// Shared encoding and default delays for the anti-theft controller, its time-parameter block and bench.
// Optional fuel-pump immobiliser is enabled by defining FUEL_PUMP_EN.
package anti_theft_pkg;

    typedef logic [3:0] tval_t;

    typedef enum logic [2:0] {
        ARMED,
        TRIGGERED,
        SOUND_ALARM,
        DISARMED,
        WAIT_OPEN,
        WAIT_CLOSE,
        ARM_DELAY
    } state_e;

    localparam tval_t T_ARM_DELAY       = 4'd6;
    localparam tval_t T_DRIVER_DELAY    = 4'd8;
    localparam tval_t T_PASSENGER_DELAY = 4'd15;
    localparam tval_t T_ALARM_ON        = 4'd10;

endpackage

// File: rtl/anti_theft_fsm_if.sv
// Sensor and countdown-timer signals of the anti-theft controller; slave = controller side.
// Fuel-pump signals (FUEL_PUMP_EN) are plain ports on the top, not part of this bundle.
interface anti_theft_fsm_if;
    import anti_theft_pkg::*;

    logic  ignition;
    logic  door_driver;
    logic  door_pass;
    logic  expired;
    logic  two_hz_enable;
    logic  start_timer;
    tval_t timer_value;
    logic  siren;
    logic  status_led;

    modport slave (
        input  ignition, door_driver, door_pass, expired, two_hz_enable,
        output start_timer, timer_value, siren, status_led
    );

    modport master (
        output ignition, door_driver, door_pass, expired, two_hz_enable,
        input  start_timer, timer_value, siren, status_led
    );

endinterface

// File: rtl/fuel_pump_ctrl.sv
// Immobiliser: pump power only after brake and hidden switch were seen together since ignition rose.
// Instantiated by anti_theft_fsm only when FUEL_PUMP_EN is defined.
module fuel_pump_ctrl
    import anti_theft_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic ignition_i,
    input  logic brake_i,
    input  logic hidden_switch_i,
    output logic pump_o
);

    logic pump_q, pump_d;

    // The latch itself is the output; dropping ignition clears it on the next edge.
    always_comb begin
        pump_d = ignition_i & (pump_q | (brake_i & hidden_switch_i));
    end

    always_ff @(posedge clock) begin
        if (!reset) pump_q <= 1'b0;
        else        pump_q <= pump_d;
    end

    assign pump_o = pump_q;

endmodule

// File: rtl/anti_theft_fsm.sv
// Anti-theft main controller: arms after the driver leaves, alarms on intrusion, drives the countdown timer.
// Define FUEL_PUMP_EN to add the brake/hidden_switch fuel-pump immobiliser ports.
module anti_theft_fsm
    import anti_theft_pkg::*;
#(
    parameter tval_t ARM_DLY  = T_ARM_DELAY,
    parameter tval_t DRV_DLY  = T_DRIVER_DELAY,
    parameter tval_t PASS_DLY = T_PASSENGER_DELAY,
    parameter tval_t ALARM_ON = T_ALARM_ON
) (
    input  logic            clock,
    input  logic            reset,
    anti_theft_fsm_if.slave bus
`ifdef FUEL_PUMP_EN
    ,
    input  logic            brake,
    input  logic            hidden_switch,
    output logic            fuel_pump_power
`endif
);

    state_e state_q, state_d;
    logic   siren_q, siren_d;
    logic   led_q, led_d;
    logic   start_q, start_d;
    tval_t  value_q, value_d;
    logic   exp_qual, open_any;

    // The timer only clears expired one edge after our load pulse, so ignore it during the pulse.
    assign exp_qual = bus.expired & ~start_q;
    assign open_any = bus.door_driver | bus.door_pass;

    always_comb begin
        state_d = state_q;
        siren_d = siren_q;
        led_d   = led_q;
        start_d = 1'b0;
        value_d = value_q;
        if (bus.ignition) begin
            state_d = DISARMED;
            siren_d = 1'b0;
            led_d   = 1'b0;
        end else begin
            case (state_q)
                ARMED: begin
                    siren_d = 1'b0;
                    if (bus.door_driver) begin
                        state_d = TRIGGERED;
                        start_d = 1'b1;
                        value_d = DRV_DLY;
                        led_d   = 1'b1;
                    end else if (bus.door_pass) begin
                        state_d = TRIGGERED;
                        start_d = 1'b1;
                        value_d = PASS_DLY;
                        led_d   = 1'b1;
                    end else if (bus.two_hz_enable) begin
                        led_d = ~led_q;
                    end
                end
                TRIGGERED: begin
                    led_d = 1'b1;
                    if (exp_qual) begin
                        state_d = SOUND_ALARM;
                        start_d = 1'b1;
                        value_d = ALARM_ON;
                        siren_d = 1'b1;
                    end
                end
                SOUND_ALARM: begin
                    siren_d = 1'b1;
                    led_d   = 1'b1;
                    // An open door keeps reloading the timer, so the siren outlasts it.
                    if (open_any) begin
                        start_d = 1'b1;
                        value_d = ALARM_ON;
                    end else if (exp_qual) begin
                        state_d = ARMED;
                        siren_d = 1'b0;
                        led_d   = 1'b0;
                    end
                end
                DISARMED: begin
                    siren_d = 1'b0;
                    led_d   = 1'b0;
                    state_d = WAIT_OPEN;
                end
                WAIT_OPEN: begin
                    if (bus.door_driver) state_d = WAIT_CLOSE;
                end
                WAIT_CLOSE: begin
                    if (!bus.door_driver) begin
                        state_d = ARM_DELAY;
                        start_d = 1'b1;
                        value_d = ARM_DLY;
                    end
                end
                ARM_DELAY: begin
                    if (open_any) begin
                        state_d = WAIT_CLOSE;
                    end else if (exp_qual) begin
                        state_d = ARMED;
                        led_d   = 1'b0;
                    end
                end
                default: begin
                    state_d = ARMED;
                    siren_d = 1'b0;
                    led_d   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= ARMED;
            siren_q <= 1'b0;
            led_q   <= 1'b0;
            start_q <= 1'b0;
            value_q <= '0;
        end else begin
            state_q <= state_d;
            siren_q <= siren_d;
            led_q   <= led_d;
            start_q <= start_d;
            value_q <= value_d;
        end
    end

    assign bus.siren       = siren_q;
    assign bus.status_led  = led_q;
    assign bus.start_timer = start_q;
    assign bus.timer_value = value_q;

`ifdef FUEL_PUMP_EN
    fuel_pump_ctrl u_fuel_pump (
        .clock           (clock),
        .reset           (reset),
        .ignition_i      (bus.ignition),
        .brake_i         (brake),
        .hidden_switch_i (hidden_switch),
        .pump_o          (fuel_pump_power)
    );
`endif

endmodule

// File: tb/tb_anti_theft_fsm.sv
// Directed scenarios plus biased random stimulus against a mode-level reference model.
// Build with FUEL_PUMP_EN defined to also exercise the immobiliser ports.
module tb_anti_theft_fsm;
    import anti_theft_pkg::*;

    logic clock = 1'b0;
    logic rst_n = 1'b0;
    always #5 clock = ~clock;

    anti_theft_fsm_if bus();

    logic brake = 1'b0;
    logic hidden = 1'b0;
`ifdef FUEL_PUMP_EN
    logic pump;
`endif

    anti_theft_fsm dut (
        .clock (clock),
        .reset (rst_n),
        .bus   (bus)
`ifdef FUEL_PUMP_EN
        ,
        .brake           (brake),
        .hidden_switch   (hidden),
        .fuel_pump_power (pump)
`endif
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Reference: a mode plus a blink bit; outputs derive from the mode, start/value are events.
    state_e m_st    = ARMED;
    logic   m_blink = 1'b0;
    logic   m_start = 1'b0;
    tval_t  m_val   = '0;
    logic   m_seen  = 1'b0;

    task automatic step_model();
        logic   ex, open_any, nstart;
        state_e nx;
        tval_t  nval;
        logic   nblink;
        ex       = bus.expired && !m_start;
        open_any = bus.door_driver || bus.door_pass;
        nx = m_st; nstart = 1'b0; nval = m_val; nblink = m_blink;
        if (!rst_n) begin
            nx = ARMED; nblink = 1'b0; nval = '0;
        end else if (bus.ignition) nx = DISARMED;
        else if (m_st == ARMED && open_any) begin
            nx = TRIGGERED; nstart = 1'b1; nval = bus.door_driver ? 4'd8 : 4'd15;
        end else if (m_st == ARMED) begin
            if (bus.two_hz_enable) nblink = !m_blink;
        end else if (m_st == TRIGGERED && ex) begin
            nx = SOUND_ALARM; nstart = 1'b1; nval = 4'd10;
        end else if (m_st == SOUND_ALARM && open_any) begin
            nstart = 1'b1; nval = 4'd10;
        end else if (m_st == SOUND_ALARM && ex) nx = ARMED;
        else if (m_st == DISARMED) nx = WAIT_OPEN;
        else if (m_st == WAIT_OPEN && bus.door_driver) nx = WAIT_CLOSE;
        else if (m_st == WAIT_CLOSE && !bus.door_driver) begin
            nx = ARM_DELAY; nstart = 1'b1; nval = 4'd6;
        end else if (m_st == ARM_DELAY && open_any) nx = WAIT_CLOSE;
        else if (m_st == ARM_DELAY && ex) nx = ARMED;
        if (nx == ARMED && m_st != ARMED) nblink = 1'b0;
        m_seen  = rst_n && bus.ignition && (m_seen || (brake && hidden));
        m_st = nx; m_start = nstart; m_val = nval; m_blink = nblink;
    endtask

    task automatic cycle(input logic r, input logic ign, input logic dd, input logic dp,
                         input logic ex, input logic hz);
        logic exp_led;
        rst_n = r; bus.ignition = ign; bus.door_driver = dd; bus.door_pass = dp;
        bus.expired = ex; bus.two_hz_enable = hz;
        step_model();
        @(posedge clock);
        @(negedge clock);
        exp_led = (m_st == ARMED) ? m_blink : (m_st == TRIGGERED || m_st == SOUND_ALARM);
        chk("siren", bus.siren, m_st == SOUND_ALARM);
        chk("status_led", bus.status_led, exp_led);
        chk("start_timer", bus.start_timer, m_start);
        chk("timer_value", bus.timer_value, m_val);
`ifdef FUEL_PUMP_EN
        chk("fuel_pump", pump, m_seen);
`endif
    endtask

    initial begin
        logic ign;
        // reset, then blink on 2 Hz pulses
        cycle(0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            cycle(1, 0, 0, 0, 0, 1);
            cycle(1, 0, 0, 0, 0, 0);
        end
        // passenger intrusion -> alarm -> re-arm; expired held through each start pulse
        cycle(1, 0, 0, 1, 0, 0);
        cycle(1, 0, 0, 0, 1, 0);
        cycle(1, 0, 0, 0, 1, 0);
        cycle(1, 0, 0, 0, 1, 0);
        cycle(1, 0, 0, 0, 1, 0);
        // both doors at once: driver delay wins; doors held open reload every cycle
        cycle(1, 0, 1, 1, 0, 0);
        cycle(1, 0, 1, 1, 1, 0);
        cycle(1, 0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) cycle(1, 0, 1, 0, 1, 0);
        // ignition disarms, then driver leaves; reopening restarts the arm delay
        cycle(1, 1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0);
        cycle(1, 0, 1, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0);
        cycle(1, 0, 1, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 1, 0);
        cycle(1, 0, 0, 0, 1, 0);
        // reset during the alarm
        cycle(1, 0, 0, 1, 0, 0);
        cycle(1, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 1, 0);
        cycle(0, 0, 1, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0);
        // immobiliser: brake alone, then brake with hidden switch, then ignition off
        brake = 1'b1;
        cycle(1, 1, 0, 0, 0, 0);
        cycle(1, 1, 0, 0, 0, 0);
        hidden = 1'b1;
        cycle(1, 1, 0, 0, 0, 0);
        brake = 1'b0; hidden = 1'b0;
        cycle(1, 1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0);
        // biased random: sticky ignition, density of doors varies per segment
        ign = 1'b0;
        for (int seg = 0; seg < 4; seg++) begin
            for (int i = 0; i < 800; i++) begin
                int dmod;
                dmod = 3 + seg * 3;
                if ($urandom_range(0, 24) == 0) ign = ~ign;
                brake  = ($urandom_range(0, 3) == 0);
                hidden = ($urandom_range(0, 3) == 0);
                cycle(($urandom_range(0, 199) != 0), ign,
                      ($urandom_range(0, dmod) == 0), ($urandom_range(0, dmod) == 0),
                      ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0));
            end
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
